// File: rtl/dma_channel_arbiter.sv
// Round-robin merge of NoC per-channel TileLink-UL masters onto one port.
// Channel index rides in the low a_source bits; D beats are routed back by decoding d_source.
module dma_channel_arbiter #(
    parameter int unsigned NoC      = 2,
    parameter int unsigned TL_RS    = 4,
    parameter int unsigned TL_AW    = 32,
    parameter int unsigned MAX_SIZE = 6
) (
    input  logic                   dma_clock_i,
    input  logic                   dma_reset_i,

    input  logic [NoC*3-1:0]       ch_a_opcode,
    input  logic [NoC*3-1:0]       ch_a_param,
    input  logic [NoC*4-1:0]       ch_a_size,
    input  logic [NoC*TL_RS-1:0]   ch_a_source,
    input  logic [NoC*TL_AW-1:0]   ch_a_address,
    input  logic [NoC*4-1:0]       ch_a_mask,
    input  logic [NoC*32-1:0]      ch_a_data,
    input  logic [NoC-1:0]         ch_a_corrupt,
    input  logic [NoC-1:0]         ch_a_valid,
    output logic [NoC-1:0]         ch_a_ready,

    output logic [NoC*3-1:0]       ch_d_opcode,
    output logic [NoC*2-1:0]       ch_d_param,
    output logic [NoC*4-1:0]       ch_d_size,
    output logic [NoC*TL_RS-1:0]   ch_d_source,
    output logic [NoC-1:0]         ch_d_denied,
    output logic [NoC*32-1:0]      ch_d_data,
    output logic [NoC-1:0]         ch_d_corrupt,
    output logic [NoC-1:0]         ch_d_valid,
    input  logic [NoC-1:0]         ch_d_ready,

    output logic [2:0]             m_a_opcode,
    output logic [2:0]             m_a_param,
    output logic [3:0]             m_a_size,
    output logic [TL_RS-1:0]       m_a_source,
    output logic [TL_AW-1:0]       m_a_address,
    output logic [3:0]             m_a_mask,
    output logic [31:0]            m_a_data,
    output logic                   m_a_corrupt,
    output logic                   m_a_valid,
    input  logic                   m_a_ready,

    input  logic [2:0]             m_d_opcode,
    input  logic [1:0]             m_d_param,
    input  logic [3:0]             m_d_size,
    input  logic [TL_RS-1:0]       m_d_source,
    input  logic                   m_d_denied,
    input  logic [31:0]            m_d_data,
    input  logic                   m_d_corrupt,
    input  logic                   m_d_valid,
    output logic                   m_d_ready,

    output logic                   bad_route_o
);

    localparam int unsigned CW = (NoC > 1) ? $clog2(NoC) : 1;
    localparam int unsigned BW = MAX_SIZE - 1;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic            bad_route_q;

    logic [CW-1:0]   scan_idx;
    logic [CW-1:0]   scan_sel;
    logic [CW-1:0]   sel;
    logic [TL_RS-1:0] sel_src;
    logic            fire;
    logic            is_burst;
    logic [BW-1:0]   req_beats;
    logic [CW-1:0]   d_ch;
    logic            route_ok;
    logic [TL_RS-1:0] d_src_out;

    function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] x);
        return (int'(x) == int'(NoC) - 1) ? '0 : x + CW'(1);
    endfunction

    // Reverse scan so the channel closest to rr_ptr wins the last assignment.
    always_comb begin
        scan_idx = '0;
        scan_sel = rr_ptr_q;
        for (int k = int'(NoC) - 1; k >= 0; k--) begin
            scan_idx = CW'((int'(rr_ptr_q) + k) % int'(NoC));
            if (ch_a_valid[scan_idx]) begin
                scan_sel = scan_idx;
            end
        end
    end

    assign sel = (state_q == StLocked) ? owner_q : scan_sel;

    assign m_a_opcode  = ch_a_opcode[int'(sel)*3 +: 3];
    assign m_a_param   = ch_a_param[int'(sel)*3 +: 3];
    assign m_a_size    = ch_a_size[int'(sel)*4 +: 4];
    assign sel_src     = ch_a_source[int'(sel)*int'(TL_RS) +: TL_RS];
    assign m_a_address = ch_a_address[int'(sel)*int'(TL_AW) +: TL_AW];
    assign m_a_mask    = ch_a_mask[int'(sel)*4 +: 4];
    assign m_a_data    = ch_a_data[int'(sel)*32 +: 32];
    assign m_a_corrupt = ch_a_corrupt[sel];
    assign m_a_valid   = ch_a_valid[sel];
    assign fire        = m_a_valid & m_a_ready;

    generate
        if (TL_RS > CW) begin : g_a_src
            logic unused_src_hi;
            assign unused_src_hi = ^sel_src[TL_RS-1 -: CW];
            assign m_a_source    = {sel_src[TL_RS-CW-1:0], sel};
        end else begin : g_a_src_narrow
            logic unused_src;
            assign unused_src = ^sel_src;
            assign m_a_source = sel;
        end
    endgenerate

    always_comb begin
        ch_a_ready = '0;
        for (int i = 0; i < int'(NoC); i++) begin
            ch_a_ready[i] = (|ch_a_valid) & m_a_ready & (sel == CW'(i));
        end
    end

    assign is_burst  = (m_a_opcode[2:1] == 2'b00) && (m_a_size > 4'd2);
    assign req_beats = is_burst ? (BW'(1) << (m_a_size - 4'd2)) : BW'(1);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beats_d  = beats_q;
        unique case (state_q)
            StIdle: begin
                if (m_a_valid && !fire) begin
                    // A stalled request keeps the grant until it is accepted.
                    state_d = StLocked;
                    owner_d = sel;
                    beats_d = req_beats;
                end else if (fire) begin
                    if (req_beats == BW'(1)) begin
                        rr_ptr_d = next_ch(sel);
                    end else begin
                        state_d = StLocked;
                        owner_d = sel;
                        beats_d = req_beats - BW'(1);
                    end
                end
            end
            StLocked: begin
                if (fire) begin
                    if (beats_q == BW'(1)) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_ch(owner_q);
                    end else begin
                        beats_d = beats_q - BW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign d_ch = m_d_source[CW-1:0];

    generate
        if (NoC == (1 << CW)) begin : g_route_full
            assign route_ok = 1'b1;
        end else begin : g_route_partial
            assign route_ok = (d_ch < CW'(NoC));
        end
        if (TL_RS > CW) begin : g_d_src
            assign d_src_out = {{CW{1'b0}}, m_d_source[TL_RS-1:CW]};
        end else begin : g_d_src_narrow
            assign d_src_out = '0;
        end
    endgenerate

    assign ch_d_opcode  = {NoC{m_d_opcode}};
    assign ch_d_param   = {NoC{m_d_param}};
    assign ch_d_size    = {NoC{m_d_size}};
    assign ch_d_source  = {NoC{d_src_out}};
    assign ch_d_denied  = {NoC{m_d_denied}};
    assign ch_d_data    = {NoC{m_d_data}};
    assign ch_d_corrupt = {NoC{m_d_corrupt}};

    always_comb begin
        ch_d_valid = '0;
        for (int i = 0; i < int'(NoC); i++) begin
            ch_d_valid[i] = m_d_valid & route_ok & (d_ch == CW'(i));
        end
    end

    // Unroutable beats are sunk so the interconnect never deadlocks on them.
    assign m_d_ready   = route_ok ? ch_d_ready[d_ch] : 1'b1;
    assign bad_route_o = bad_route_q;

    always_ff @(posedge dma_clock_i) begin
        if (dma_reset_i) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beats_q     <= '0;
            bad_route_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beats_q     <= beats_d;
            bad_route_q <= m_d_valid & ~route_ok;
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench: a NoC=2 arbiter for A/D behaviour and a NoC=3 arbiter for bad routes.
module tb_dma_channel_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // NoC = 2 instance
    logic [5:0]  a_opcode, a_param;
    logic [7:0]  a_size, a_source, a_mask;
    logic [63:0] a_address, a_data;
    logic [1:0]  a_corrupt, a_valid, a_ready;
    logic [5:0]  d_opcode;
    logic [3:0]  d_param;
    logic [7:0]  d_size, d_source;
    logic [1:0]  d_denied, d_corrupt, d_valid, d_ready;
    logic [63:0] d_data;
    logic [2:0]  ma_opcode, ma_param;
    logic [3:0]  ma_size, ma_source, ma_mask;
    logic [31:0] ma_address, ma_data;
    logic        ma_corrupt, ma_valid, ma_ready;
    logic [2:0]  md_opcode;
    logic [1:0]  md_param;
    logic [3:0]  md_size, md_source;
    logic [31:0] md_data;
    logic        md_denied, md_corrupt, md_valid, md_ready;
    logic        bad2;

    // NoC = 3 instance
    logic [8:0]  t_a_opcode, t_a_param;
    logic [11:0] t_a_size, t_a_source, t_a_mask;
    logic [95:0] t_a_address, t_a_data;
    logic [2:0]  t_a_corrupt, t_a_valid, t_a_ready;
    logic [8:0]  t_d_opcode;
    logic [5:0]  t_d_param;
    logic [11:0] t_d_size, t_d_source;
    logic [2:0]  t_d_denied, t_d_corrupt, t_d_valid, t_d_ready;
    logic [95:0] t_d_data;
    logic [2:0]  t_ma_opcode, t_ma_param;
    logic [3:0]  t_ma_size, t_ma_source, t_ma_mask;
    logic [31:0] t_ma_address, t_ma_data;
    logic        t_ma_corrupt, t_ma_valid, t_ma_ready;
    logic [3:0]  t_md_source;
    logic        t_md_valid, t_md_ready;
    logic        bad3;

    dma_channel_arbiter #(.NoC(2), .TL_RS(4), .TL_AW(32), .MAX_SIZE(6)) u_dut2 (
        .dma_clock_i(clk), .dma_reset_i(rst),
        .ch_a_opcode(a_opcode), .ch_a_param(a_param), .ch_a_size(a_size),
        .ch_a_source(a_source), .ch_a_address(a_address), .ch_a_mask(a_mask),
        .ch_a_data(a_data), .ch_a_corrupt(a_corrupt), .ch_a_valid(a_valid),
        .ch_a_ready(a_ready),
        .ch_d_opcode(d_opcode), .ch_d_param(d_param), .ch_d_size(d_size),
        .ch_d_source(d_source), .ch_d_denied(d_denied), .ch_d_data(d_data),
        .ch_d_corrupt(d_corrupt), .ch_d_valid(d_valid), .ch_d_ready(d_ready),
        .m_a_opcode(ma_opcode), .m_a_param(ma_param), .m_a_size(ma_size),
        .m_a_source(ma_source), .m_a_address(ma_address), .m_a_mask(ma_mask),
        .m_a_data(ma_data), .m_a_corrupt(ma_corrupt), .m_a_valid(ma_valid),
        .m_a_ready(ma_ready),
        .m_d_opcode(md_opcode), .m_d_param(md_param), .m_d_size(md_size),
        .m_d_source(md_source), .m_d_denied(md_denied), .m_d_data(md_data),
        .m_d_corrupt(md_corrupt), .m_d_valid(md_valid), .m_d_ready(md_ready),
        .bad_route_o(bad2)
    );

    dma_channel_arbiter #(.NoC(3), .TL_RS(4), .TL_AW(32), .MAX_SIZE(6)) u_dut3 (
        .dma_clock_i(clk), .dma_reset_i(rst),
        .ch_a_opcode(t_a_opcode), .ch_a_param(t_a_param), .ch_a_size(t_a_size),
        .ch_a_source(t_a_source), .ch_a_address(t_a_address), .ch_a_mask(t_a_mask),
        .ch_a_data(t_a_data), .ch_a_corrupt(t_a_corrupt), .ch_a_valid(t_a_valid),
        .ch_a_ready(t_a_ready),
        .ch_d_opcode(t_d_opcode), .ch_d_param(t_d_param), .ch_d_size(t_d_size),
        .ch_d_source(t_d_source), .ch_d_denied(t_d_denied), .ch_d_data(t_d_data),
        .ch_d_corrupt(t_d_corrupt), .ch_d_valid(t_d_valid), .ch_d_ready(t_d_ready),
        .m_a_opcode(t_ma_opcode), .m_a_param(t_ma_param), .m_a_size(t_ma_size),
        .m_a_source(t_ma_source), .m_a_address(t_ma_address), .m_a_mask(t_ma_mask),
        .m_a_data(t_ma_data), .m_a_corrupt(t_ma_corrupt), .m_a_valid(t_ma_valid),
        .m_a_ready(t_ma_ready),
        .m_d_opcode(md_opcode), .m_d_param(md_param), .m_d_size(md_size),
        .m_d_source(t_md_source), .m_d_denied(md_denied), .m_d_data(md_data),
        .m_d_corrupt(md_corrupt), .m_d_valid(t_md_valid), .m_d_ready(t_md_ready),
        .bad_route_o(bad3)
    );

    // Requests larger than MAX_SIZE are illegal stimulus.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (a_valid[i] && (a_size[i*4 +: 4] > 4'd6)) $error("illegal a_size on channel %0d", i);
        end
    end

    task automatic set_ch(input int ch, input logic [2:0] op, input logic [3:0] sz,
                          input logic [3:0] src, input logic [31:0] addr);
        a_opcode[ch*3 +: 3]   = op;
        a_param[ch*3 +: 3]    = 3'd0;
        a_size[ch*4 +: 4]     = sz;
        a_source[ch*4 +: 4]   = src;
        a_address[ch*32 +: 32] = addr;
        a_mask[ch*4 +: 4]     = 4'hF;
        a_data[ch*32 +: 32]   = addr ^ 32'hA5A5_0000;
        a_corrupt[ch]         = 1'b0;
    endtask

    // Tasks begin and end on a falling edge; outputs are sampled 1 time unit later.
    task automatic test_reset();
        rst = 1'b1;
        a_opcode = '0; a_param = '0; a_size = '0; a_source = '0; a_address = '0;
        a_mask = '0; a_data = '0; a_corrupt = '0; a_valid = '0; ma_ready = 1'b0;
        d_ready = '0; md_opcode = '0; md_param = '0; md_size = '0; md_source = '0;
        md_denied = 1'b0; md_data = '0; md_corrupt = 1'b0; md_valid = 1'b0;
        t_a_opcode = '0; t_a_param = '0; t_a_size = '0; t_a_source = '0; t_a_address = '0;
        t_a_mask = '0; t_a_data = '0; t_a_corrupt = '0; t_a_valid = '0; t_ma_ready = 1'b0;
        t_d_ready = '0; t_md_source = '0; t_md_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ma_valid !== 1'b0) begin errors++; $display("FAIL reset_m_a_valid: got %b expected 0", ma_valid); end
        checks++; if (a_ready !== 2'b00) begin errors++; $display("FAIL reset_ch_a_ready: got %b expected 00", a_ready); end
        checks++; if (bad2 !== 1'b0) begin errors++; $display("FAIL reset_bad_route: got %b expected 0", bad2); end
        checks++; if (d_valid !== 2'b00) begin errors++; $display("FAIL reset_ch_d_valid: got %b expected 00", d_valid); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_src;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_addr;
        set_ch(0, 3'd4, 4'd2, 4'b0110, 32'h0000_1000);
        set_ch(1, 3'd4, 4'd2, 4'b0011, 32'h0000_2000);
        a_valid  = 2'b11;
        ma_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_src  = (i % 2 == 0) ? 4'b1100 : 4'b0111;
            exp_rdy  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
            checks++; if (ma_source !== exp_src) begin errors++; $display("FAIL rr_source[%0d]: got %b expected %b", i, ma_source, exp_src); end
            checks++; if (a_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, a_ready, exp_rdy); end
            checks++; if (ma_address !== exp_addr) begin errors++; $display("FAIL rr_address[%0d]: got %h expected %h", i, ma_address, exp_addr); end
            @(negedge clk);
        end
        a_valid = 2'b00;
    endtask

    task automatic test_burst();
        logic [1:0] exp_rdy;
        logic [2:0] exp_op;
        a_valid = 2'b01;
        #1;
        checks++; if (a_ready !== 2'b01) begin errors++; $display("FAIL burst_pre_ready: got %b expected 01", a_ready); end
        @(negedge clk);
        set_ch(1, 3'd0, 4'd4, 4'b0001, 32'h0000_3000);
        a_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_rdy = (i < 4) ? 2'b10 : 2'b01;
            exp_op  = (i < 4) ? 3'd0 : 3'd4;
            checks++; if (a_ready !== exp_rdy) begin errors++; $display("FAIL burst_ready[%0d]: got %b expected %b", i, a_ready, exp_rdy); end
            checks++; if (ma_opcode !== exp_op) begin errors++; $display("FAIL burst_opcode[%0d]: got %0d expected %0d", i, ma_opcode, exp_op); end
            @(negedge clk);
        end
        a_valid = 2'b00;
    endtask

    task automatic test_stall();
        set_ch(1, 3'd4, 4'd2, 4'b0011, 32'h0000_2000);
        a_valid  = 2'b01;
        ma_ready = 1'b0;
        #1;
        checks++; if (ma_valid !== 1'b1) begin errors++; $display("FAIL stall_valid0: got %b expected 1", ma_valid); end
        checks++; if (ma_source[0] !== 1'b0) begin errors++; $display("FAIL stall_src0: got %b expected 0", ma_source[0]); end
        @(negedge clk);
        a_valid = 2'b11;
        #1;
        checks++; if (ma_source[0] !== 1'b0) begin errors++; $display("FAIL stall_src1: got %b expected 0", ma_source[0]); end
        checks++; if (a_ready !== 2'b00) begin errors++; $display("FAIL stall_ready1: got %b expected 00", a_ready); end
        @(negedge clk);
        a_valid = 2'b10;
        #1;
        checks++; if (ma_valid !== 1'b0) begin errors++; $display("FAIL stall_owner_drop: got %b expected 0", ma_valid); end
        @(negedge clk);
        a_valid  = 2'b11;
        ma_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 2'b01) begin errors++; $display("FAIL stall_fire0: got %b expected 01", a_ready); end
        checks++; if (ma_source[0] !== 1'b0) begin errors++; $display("FAIL stall_src3: got %b expected 0", ma_source[0]); end
        @(negedge clk);
        #1;
        checks++; if (a_ready !== 2'b10) begin errors++; $display("FAIL stall_then_ch1: got %b expected 10", a_ready); end
        @(negedge clk);
        a_valid  = 2'b00;
        ma_ready = 1'b0;
    endtask

    task automatic test_d_route();
        md_valid  = 1'b1;
        md_source = 4'b0101;
        md_data   = 32'hCAFE_F00D;
        md_opcode = 3'd1;
        d_ready   = 2'b10;
        #1;
        checks++; if (d_valid !== 2'b10) begin errors++; $display("FAIL d_valid_ch1: got %b expected 10", d_valid); end
        checks++; if (d_source[7:4] !== 4'b0010) begin errors++; $display("FAIL d_source_ch1: got %b expected 0010", d_source[7:4]); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL d_ready_ch1: got %b expected 1", md_ready); end
        checks++; if (d_data[31:0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL d_data_bcast: got %h expected cafef00d", d_data[31:0]); end
        checks++; if (d_opcode[5:3] !== 3'd1) begin errors++; $display("FAIL d_opcode_ch1: got %0d expected 1", d_opcode[5:3]); end
        d_ready = 2'b01;
        #1;
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL d_backpressure: got %b expected 0", md_ready); end
        md_source = 4'b0110;
        #1;
        checks++; if (d_valid !== 2'b01) begin errors++; $display("FAIL d_valid_ch0: got %b expected 01", d_valid); end
        checks++; if (d_source[3:0] !== 4'b0011) begin errors++; $display("FAIL d_source_ch0: got %b expected 0011", d_source[3:0]); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL d_ready_ch0: got %b expected 1", md_ready); end
        md_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bad_route();
        t_md_valid  = 1'b1;
        t_md_source = 4'b0111;
        t_d_ready   = 3'b000;
        #1;
        checks++; if (t_md_ready !== 1'b1) begin errors++; $display("FAIL bad_sink_ready: got %b expected 1", t_md_ready); end
        checks++; if (t_d_valid !== 3'b000) begin errors++; $display("FAIL bad_no_valid: got %b expected 000", t_d_valid); end
        checks++; if (bad3 !== 1'b0) begin errors++; $display("FAIL bad_early: got %b expected 0", bad3); end
        @(negedge clk);
        t_md_valid = 1'b0;
        #1;
        checks++; if (bad3 !== 1'b1) begin errors++; $display("FAIL bad_pulse: got %b expected 1", bad3); end
        @(negedge clk);
        #1;
        checks++; if (bad3 !== 1'b0) begin errors++; $display("FAIL bad_one_cycle: got %b expected 0", bad3); end
        t_md_valid  = 1'b1;
        t_md_source = 4'b1010;
        t_d_ready   = 3'b100;
        #1;
        checks++; if (t_d_valid !== 3'b100) begin errors++; $display("FAIL noc3_valid_ch2: got %b expected 100", t_d_valid); end
        checks++; if (t_d_source[11:8] !== 4'b0010) begin errors++; $display("FAIL noc3_source_ch2: got %b expected 0010", t_d_source[11:8]); end
        checks++; if (t_md_ready !== 1'b1) begin errors++; $display("FAIL noc3_ready_ch2: got %b expected 1", t_md_ready); end
        @(negedge clk);
        t_md_valid = 1'b0;
        #1;
        checks++; if (bad3 !== 1'b0) begin errors++; $display("FAIL noc3_good_no_pulse: got %b expected 0", bad3); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        set_ch(1, 3'd0, 4'd4, 4'b0001, 32'h0000_3000);
        a_valid  = 2'b10;
        ma_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (a_ready !== 2'b10) begin errors++; $display("FAIL mid_burst_beat[%0d]: got %b expected 10", i, a_ready); end
            @(negedge clk);
        end
        rst      = 1'b1;
        a_valid  = 2'b11;
        ma_ready = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        ma_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 2'b01) begin errors++; $display("FAIL post_reset_grant: got %b expected 01", a_ready); end
        checks++; if (ma_opcode !== 3'd4) begin errors++; $display("FAIL post_reset_opcode: got %0d expected 4", ma_opcode); end
        @(negedge clk);
        a_valid  = 2'b00;
        ma_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_stall();
        test_d_route();
        test_bad_route();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_channel_arbiter.md
# dma_channel_arbiter

Round-robin arbiter that merges the NoC per-channel TileLink-UL master ports of the multi-channel DMA controller into one TileLink-UL master port toward the system interconnect. Per-channel A requests are granted one at a time. Multi-beat Put bursts and stalled requests hold the grant. The channel index is encoded into the low bits of `a_source`, and D responses are routed back to the issuing channel by decoding `d_source`.

## Interface
Parameters:
- `NoC`, 2: number of DMA channels (≥1).
- `TL_RS`, 4: source width, both sides; must be ≥ CW, where CW = max(1, $clog2(NoC)).
- `TL_AW`, 32: address width.
- `MAX_SIZE`, 6: largest legal `a_size`/`d_size` (log2 bytes); beat counter is MAX_SIZE-1 bits wide.

Ports:
- `dma_clock_i` in 1: clock; one clock, all state on rising edge.
- `dma_reset_i` in 1: reset, synchronous, active-high.
- `ch_a_opcode/param/size/source/address/mask/data/corrupt` in: NoC-packed A fields. Per-channel widths are 3/3/4/TL_RS/TL_AW/4/32/1.
- `ch_a_valid` in NoC, `ch_a_ready` out NoC: per-channel A handshake.
- `ch_d_opcode/param/size/source/denied/data/corrupt` out: NoC-packed D fields. Per-channel widths are 3/2/4/TL_RS/1/32/1.
- `ch_d_valid` out NoC, `ch_d_ready` in NoC: per-channel D handshake.
- `m_a_opcode/param/size/source/address/mask/data/corrupt` out: merged A.
- `m_a_valid` out 1, `m_a_ready` in 1.
- `m_d_opcode/param/size/source/denied/data/corrupt` in: merged D.
- `m_d_valid` in 1, `m_d_ready` out 1.
- `bad_route_o` out 1: one-cycle pulse when a D beat decodes to a nonexistent channel.

## Operation
State:
- `locked` (reset 0)
- `owner` [CW] (reset 0)
- `rr_ptr` [CW] (reset 0)
- `beats_left` (reset 0)
- `bad_route_o` register (reset 0)

Selection (combinational):
- If `locked`: sel = `owner`.
- Otherwise: sel = first channel i with `ch_a_valid[i]=1`, scanning rr_ptr, rr_ptr+1, … mod NoC.
- No valid channel: `m_a_valid`=0 and all `ch_a_ready`=0.

A path (combinational mux, no added latency):
- `m_a_*` = channel sel's fields.
- `m_a_valid` = `ch_a_valid[sel]`.
- `ch_a_ready[sel]` = `m_a_ready`; all other `ch_a_ready` = 0.
- `m_a_source` = {ch_a_source[sel][TL_RS-CW-1:0], sel[CW-1:0]}.
- fire = `m_a_valid & m_a_ready`.

Beats:
- Opcode 0/1 (Put) with size > 2: beats = 1 << (size-2).
- All other requests (Get = 4, size ≤ 2): 1 beat.
- Size > MAX_SIZE is illegal; the bench asserts on it and the RTL behaviour is unspecified.

FSM (IDLE = !locked, LOCKED = locked):
- IDLE, `m_a_valid` and not fire → LOCKED; owner=sel, beats_left=beats. The grant may not move off a pending request.
- IDLE, fire with beats=1 → stay IDLE; rr_ptr = sel+1 mod NoC.
- IDLE, fire with beats>1 → LOCKED; owner=sel, beats_left=beats-1.
- LOCKED, fire with beats_left=1 → IDLE; rr_ptr = owner+1 mod NoC.
- LOCKED, fire otherwise → beats_left-1.
- LOCKED, no fire → hold. This holds even if `ch_a_valid[owner]` drops (TileLink violation); the grant is not released.

D path (combinational, stateless):
- c = `m_d_source[CW-1:0]`.
- If c < NoC:
  - `ch_d_valid[c]` = `m_d_valid`; other `ch_d_valid` = 0.
  - `m_d_ready` = `ch_d_ready[c]`.
  - `ch_d_source[c]` = {CW zeros, m_d_source[TL_RS-1:CW]}.
  - All other D fields broadcast to every channel.
- If c ≥ NoC (non-power-of-2 NoC):
  - `m_d_ready`=1 and the beat is dropped.
  - `bad_route_o` pulses high the next cycle.
- A and D are independent; simultaneous A fire and D beat are both serviced in the same cycle.

## Timing
- A and D latency: 0 cycles (pure mux); state updates on the clock edge after fire.
- Reset mid-burst: state returns to IDLE/rr_ptr=0 on the next edge; the in-flight burst is abandoned. Channels are reset by the same `dma_reset_i`.
- Fairness: a continuously requesting channel waits at most NoC-1 grants.

## Test plan
- NoC=2, both channels request a 1-beat Get (size 2) every cycle, `m_a_ready`=1 → grants alternate ch0, ch1, ch0…; `m_a_source` low bit = 0, 1, 0…
- ch1 issues PutFull size 4 (4 beats) while ch0 is valid → 4 consecutive ch1 beats, `ch_a_ready[0]`=0 throughout; ch0 is granted on the 5th cycle.
- ch0 valid, `m_a_ready`=0 for 3 cycles, ch1 raises valid in cycle 1 → owner stays ch0; ch0 fires in cycle 4, then ch1.
- D beat with `m_d_source`=0b0101 (CW=1) → `ch_d_valid[1]`=1 and `ch_d_source[1]`=0b0010; `ch_d_ready[1]`=0 back-pressures `m_d_ready`=0.
- NoC=3, `m_d_source[1:0]`=3 → `m_d_ready`=1, no `ch_d_valid`, `bad_route_o`=1 for exactly one cycle.
- Assert `dma_reset_i` after the 2nd beat of a 4-beat burst → next cycle locked=0, rr_ptr=0; with ch0 and ch1 both valid after reset, ch0 is granted.
